// File: rtl/lru_replacement_ctrl_pkg.sv
// Shared types and encode helpers for the LRU replacement controller.
package lru_ctrl_pkg;

  localparam int unsigned MAX_WAYS     = 32;
  localparam int unsigned MAX_WAY_BITS = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    RESOLVE = 3'd2,
    UPDATE  = 3'd3,
    RESP    = 3'd4
  } lru_state_e;

  // Lowest set bit wins; an all-zero vector encodes to way 0.
  function automatic logic [MAX_WAY_BITS-1:0] onehot_to_way(input logic [MAX_WAYS-1:0] vec);
    logic [MAX_WAY_BITS-1:0] way;
    logic                    found;
    way   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_WAYS; i++) begin
      if (vec[i] && !found) begin
        way   = MAX_WAY_BITS'(i);
        found = 1'b1;
      end
    end
    return way;
  endfunction

  function automatic logic [MAX_WAY_BITS-1:0] lowest_zero(input logic [MAX_WAYS-1:0] vec);
    return onehot_to_way(~vec);
  endfunction

endpackage

// File: rtl/lru_replacement_ctrl_hit_fifo.sv
// Synchronous FIFO buffering {index, way} hit updates; push is refused when full.
module lru_hit_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [CNT_BITS-1:0] count;
  logic                do_push;
  logic                do_pop;

  assign full     = (count == CNT_BITS'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  function automatic logic [PTR_BITS-1:0] ptr_next(input logic [PTR_BITS-1:0] p);
    return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + PTR_BITS'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_BITS'(1);
        2'b01:   count <= count - CNT_BITS'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lru_replacement_ctrl.sv
// Sequences one LRU instance: buffered hit updates plus miss victim selection.
// Define LRU_WAY_LOCK_EN to add lock_mask, which excludes ways from victim choice.
module lru_replacement_ctrl
  import lru_ctrl_pkg::*;
#(
  parameter int unsigned NUM_WAYS       = 4,
  parameter int unsigned INDEX_BITS     = 8,
  parameter int unsigned WAY_BITS       = $clog2(NUM_WAYS),
  parameter int unsigned HIT_FIFO_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  hit_valid,
  input  logic [INDEX_BITS-1:0] hit_index,
  input  logic [WAY_BITS-1:0]   hit_way,
  output logic                  hit_ready,
  input  logic                  miss_valid,
  input  logic [INDEX_BITS-1:0] miss_index,
  input  logic [NUM_WAYS-1:0]   miss_way_valid,
  output logic                  miss_ready,
  output logic                  victim_valid,
  output logic [WAY_BITS-1:0]   victim_way,
  output logic [INDEX_BITS-1:0] victim_index,
  output logic                  victim_was_invalid,
  input  logic                  victim_ready,
  output logic [INDEX_BITS-1:0] lru_current_index,
  output logic [WAY_BITS-1:0]   lru_access,
  output logic                  lru_access_valid,
  input  logic [NUM_WAYS-1:0]   lru_in
`ifdef LRU_WAY_LOCK_EN
  ,
  input  logic [NUM_WAYS-1:0]   lock_mask
`endif
);

  lru_state_e            state_q;
  logic [INDEX_BITS-1:0] idx_q;
  logic [NUM_WAYS-1:0]   valid_q;
  logic [WAY_BITS-1:0]   way_q;
  logic                  inv_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  drain;
  logic [INDEX_BITS-1:0] fifo_index;
  logic [WAY_BITS-1:0]   fifo_way;

  logic [NUM_WAYS-1:0]   lock_eff;
  logic [NUM_WAYS-1:0]   cand_inv;
  logic [MAX_WAYS-1:0]   lru_pad;
  logic [MAX_WAYS-1:0]   inv_pad;
  logic [MAX_WAYS-1:0]   lock_pad;
  logic [WAY_BITS-1:0]   lru_way;
  logic [WAY_BITS-1:0]   way_d;
  logic                  inv_d;

  assign hit_ready  = !reset && !fifo_full;
  assign miss_ready = !reset && (state_q == IDLE) && fifo_empty;

  // The LRU port is free for a hit drain only outside the lookup/update window of a miss.
  assign drain = !reset && !fifo_empty && ((state_q == IDLE) || (state_q == RESP));

  lru_hit_fifo #(
    .DEPTH (HIT_FIFO_DEPTH),
    .WIDTH (INDEX_BITS + WAY_BITS)
  ) u_hit_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (hit_valid && hit_ready),
    .push_data ({hit_index, hit_way}),
    .pop       (drain),
    .pop_data  ({fifo_index, fifo_way}),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    lock_eff = '0;
`ifdef LRU_WAY_LOCK_EN
    if (!(&lock_mask)) lock_eff = lock_mask;
`endif
    cand_inv = ~valid_q & ~lock_eff;
    lru_pad  = '0;
    lru_pad[NUM_WAYS-1:0] = lru_in;
    inv_pad  = '0;
    inv_pad[NUM_WAYS-1:0] = cand_inv;
    lock_pad = '1;
    lock_pad[NUM_WAYS-1:0] = lock_eff;
    lru_way  = WAY_BITS'(onehot_to_way(lru_pad));
    way_d    = '0;
    inv_d    = 1'b0;
    if (|cand_inv) begin
      way_d = WAY_BITS'(onehot_to_way(inv_pad));
      inv_d = 1'b1;
    end else if (!lock_eff[lru_way]) begin
      way_d = lru_way;
    end else begin
      way_d = WAY_BITS'(lowest_zero(lock_pad));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= '0;
      way_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_valid && miss_ready) begin
            idx_q   <= miss_index;
            valid_q <= miss_way_valid;
            state_q <= LOOKUP;
          end
        end
        LOOKUP:  state_q <= RESOLVE;
        RESOLVE: begin
          way_q   <= way_d;
          inv_q   <= inv_d;
          state_q <= UPDATE;
        end
        UPDATE:  state_q <= RESP;
        RESP:    if (victim_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    lru_access_valid  = drain || (!reset && (state_q == UPDATE));
    lru_current_index = '0;
    lru_access        = '0;
    if (!reset) begin
      lru_current_index = idx_q;
      if (state_q == UPDATE) begin
        lru_access = way_q;
      end else if (drain) begin
        lru_current_index = fifo_index;
        lru_access        = fifo_way;
      end
    end
  end

  assign victim_valid       = (state_q == RESP);
  assign victim_way         = way_q;
  assign victim_index       = idx_q;
  assign victim_was_invalid = inv_q;

endmodule
